uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- Serial receive engine for the UART: recovers frames from the asynchronous rx_pin using a 16x oversampling enable from the baud generator.
- Delivers each byte with a one-cycle done strobe and per-frame error flags to the RX FIFO write side.
- It is the receiving end of the tx_pin stream produced by the UART transmit path; in loopback it sits between rx_pin and the RX FIFO.

Parameters:
- DBIT, 8: data bits per frame, 5..8, LSB first.
- OVERSAMPLE, 16: s_tick pulses per bit period; must be even, at least 8.
- PARITY_EN, 0: 1 = one parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
- clk, input, 1: system clock (50 MHz nominal).
- reset_n, input, 1: asynchronous, active-low reset.
- s_tick, input, 1: single-cycle oversample enable, OVERSAMPLE per bit (same source that produces BCLK_RX).
- rx_pin, input, 1: serial line, idle high, asynchronous to clk.
- rx_data, output, DBIT: last received data word.
- rx_done, output, 1: one-clk pulse; rx_data and error flags are valid in the same cycle.
- frame_err, output, 1: stop bit sampled 0 for the frame that rx_done flags.
- parity_err, output, 1: parity mismatch for that frame; always 0 when PARITY_EN=0.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Input synchronisation:
  - rx_pin passes through a 2-flop synchroniser that resets to 1.
  - All decisions use the synchronised value rx_s, which lags rx_pin by 2 clk.
- Reset values:
  - Asynchronous reset forces state IDLE, all counters 0 and shift register 0.
  - Outputs: rx_data=0, rx_done=0, frame_err=0, parity_err=0, busy=0.
  - Reset mid-frame abandons the frame; no rx_done is issued for it.
- Counters:
  - tick_cnt is 0..OVERSAMPLE-1 and advances only on s_tick.
  - bit_cnt is 0..DBIT-1.
- State IDLE:
  - On rx_s=0, go to START with tick_cnt=0.
  - No s_tick is needed to leave IDLE.
- State START:
  - On s_tick with tick_cnt=OVERSAMPLE/2-1 (mid start bit): if rx_s=0, go to DATA with tick_cnt=0 and bit_cnt=0.
  - If rx_s=1 at that point, treat it as a glitch: return to IDLE and issue no strobe.
- State DATA:
  - On s_tick with tick_cnt=OVERSAMPLE-1: shift rx_s into the MSB of shreg (shift right) and set tick_cnt=0.
  - When bit_cnt=DBIT-1 at that point, go to PARITY if PARITY_EN=1, else STOP.
- State PARITY:
  - Sample at tick_cnt=OVERSAMPLE-1.
  - Set par_bad = XOR(shreg, sampled bit) XOR PARITY_ODD, i.e. 0 when correct. Go to STOP.
- State STOP:
  - Sample at tick_cnt=OVERSAMPLE-1, which is mid stop bit.
  - In the next clk: rx_done=1, rx_data=shreg (DBIT bits, right-aligned), parity_err=par_bad, frame_err=~stop_sample.
  - If the stop sample is 1, go to IDLE. This permits a back-to-back start only half a bit later.
  - If the stop sample is 0, go to BRK_WAIT.
- State BRK_WAIT:
  - Stay while rx_s=0, so a held-low line (break) produces exactly one rx_done.
  - Go to IDLE on rx_s=1.
- Flag timing:
  - frame_err and parity_err are updated only with rx_done and hold until the next rx_done or reset.
  - rx_data holds likewise.
- No clocking on s_tick: s_tick outside the sample points only advances tick_cnt; s_tick in IDLE is ignored.
- Latency:
  - rx_done is asserted 1 clk after the s_tick that samples the stop bit.
  - That is about (1 + DBIT + PARITY_EN + 0.5) bit periods plus 3 clk after the start-bit falling edge on rx_pin.

Decomposition:
- Shared package uart_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - default constants OVERSAMPLE_DEF=16, DBIT_DEF=8.
  - The TX engine reuses the same constants.
- One sub-module, sync_2ff: 1-bit two-flop synchroniser with parameterised reset value, here 1.

Test Plan:
- Default parameters, s_tick every 4 clk, serial 0x55 (8N1) on rx_pin:
  - Exactly one rx_done with rx_data=0x55, frame_err=0, parity_err=0.
  - busy falls within 1 clk of rx_done.
- rx_pin low for 4 ticks (quarter bit), then high:
  - No rx_done; busy returns to 0 after the mid-start sample.
  - A following 0x4E frame is received as 0x4E.
- Frame 0xA3 with stop bit 0, line then held low for 3 bit periods before going high:
  - One rx_done with rx_data=0xA3 and frame_err=1.
  - No second rx_done while the line is low; the next frame 0x0F is received with frame_err=0.
- PARITY_EN=1, PARITY_ODD=0:
  - 0x0F with parity bit 0 gives parity_err=0.
  - 0x0F with parity bit 1 gives parity_err=1.
  - rx_data=0x0F in both cases.
- Back-to-back frames 0x4E then 0xF0 with no idle gap:
  - Two rx_done pulses one frame time apart, carrying 0x4E then 0xF0, no errors.
- reset_n pulsed low for 3 clk during data bit 3 of 0xFF:
  - All outputs 0 immediately and no rx_done for the aborted frame.
  - After the line idles for 1 bit, frame 0xFF is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM states and default frame constants.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DBIT_DEF       = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous input, reset to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: oversampled start/data/parity/stop recovery with per-frame
// done strobe and frame/parity error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = DBIT_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx_pin,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done,
  output logic            frame_err,
  output logic            parity_err,
  output logic            busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DBIT);
  localparam logic        PAR_ODD_B = 1'(PARITY_ODD);

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (rx_pin),
    .q     (rx_s)
  );

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DBIT-1:0]   shreg_q, shreg_d;
  logic              par_bad_q, par_bad_d;
  logic [DBIT-1:0]   rx_data_q, rx_data_d;
  logic              rx_done_q, rx_done_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              busy_q, busy_d;
  logic              mid_start, bit_end;

  assign mid_start = s_tick && (tick_q == TW'(OVERSAMPLE/2 - 1));
  assign bit_end   = s_tick && (tick_q == TW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      par_bad_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      par_bad_q    <= par_bad_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    par_bad_d    = par_bad_q;
    rx_data_d    = rx_data_q;
    rx_done_d    = 1'b0;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;

    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // A line that is high again at mid start bit was a glitch.
        if (mid_start) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          tick_d  = '0;
          shreg_d = {rx_s, shreg_q[DBIT-1:1]};
          if (bit_q == BW'(DBIT - 1)) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          tick_d    = '0;
          par_bad_d = (^shreg_q) ^ rx_s ^ PAR_ODD_B;
          state_d   = STOP;
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          tick_d       = '0;
          rx_done_d    = 1'b1;
          rx_data_d    = shreg_q;
          parity_err_d = par_bad_q;
          frame_err_d  = ~rx_s;
          state_d      = rx_s ? IDLE : BRK_WAIT;
        end else if (s_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
      BRK_WAIT: begin
        // Hold off on a break so a low line yields only one strobe.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign rx_data    = rx_data_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = busy_q;

endmodule
